// File: rtl/sub16_nibble_seq.sv
// Purpose : iterative A - B - BI subtractor, one 4-bit section per clock, with AVR SREG flags.
// Latency : done_o in the NSEC+1'th busy cycle after the start sample edge (5 for WIDTH=16).
// Backpr. : none; start_i is ignored while busy_o=1, next start accepted in first IDLE cycle.
//
// Ports:
//   clk, rst            core clock (rising edge), asynchronous active-high reset
//   start_i             operation request, sampled only while busy_o=0
//   a_i, b_i, bi_i      minuend, subtrahend, borrow-in (SBC/CPC carry)
//   zc_i                previous Z flag for the SBC/CPC Z chain
//   busy_o, done_o      operation in progress / one-cycle completion pulse
//   d_o                 difference, updated only at completion
//   c_o z_o n_o v_o s_o h_o   AVR arithmetic flags, updated with d_o
//
// Optional feature: define SUB16_ZCHAIN_EN to make Z = (r == 0) & zc_i (latched at start),
// so a multi-byte SBC/CPC chain can only clear Z. Without it zc_i is ignored.
//
// WIDTH must be a multiple of 4 and at least 8; NSEC is derived from it.

module sub16_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bi_i,
  input  logic             zc_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] d_o,
  output logic             c_o,
  output logic             z_o,
  output logic             n_o,
  output logic             v_o,
  output logic             s_o,
  output logic             h_o
);

  localparam int NSEC = WIDTH / 4;
  localparam int CW   = (NSEC > 1) ? $clog2(NSEC) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    secCnt;
  // Operands are shifted right one section per step, so the active nibble is always [3:0].
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  // Result is assembled by shifting each new section in at the top; after NSEC steps
  // it is aligned. Kept separate from d_o so partial results never appear outside.
  logic [WIDTH-1:0] resSh;
  logic             borrow;
  logic             hReg;
  // Operand sign bits are kept aside because the shift registers lose them.
  logic             aMsb;
  logic             bMsb;

`ifdef SUB16_ZCHAIN_EN
  logic             zcLat;
`else
  logic             unusedZc;
  assign unusedZc = zc_i;
`endif

  // Section arithmetic: subtraction done as a + ~b + ~borrow; carry-out set means no borrow.
  logic [4:0]       sum5;
  logic             borrowNext;
  logic             lastSec;
  logic [WIDTH-1:0] resFinal;
  logic             rZero;
  logic             zFinal;
  logic             vFinal;
  logic             nFinal;

  assign sum5       = {1'b0, aSh[3:0]} + {1'b0, ~bSh[3:0]} + {4'b0000, ~borrow};
  assign borrowNext = ~sum5[4];
  assign lastSec    = (secCnt == CW'(NSEC - 1));

  // Full result as it will look once the current (last) section is stored.
  assign resFinal   = {sum5[3:0], resSh[WIDTH-1:4]};
  assign rZero      = (resFinal == '0);
  assign nFinal     = resFinal[WIDTH-1];
  assign vFinal     = (aMsb & ~bMsb & ~nFinal) | (~aMsb & bMsb & nFinal);

`ifdef SUB16_ZCHAIN_EN
  assign zFinal     = rZero & zcLat;
`else
  assign zFinal     = rZero;
`endif

  // busy covers both the RUN cycles and the DONE cycle.
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      secCnt <= '0;
      aSh    <= '0;
      bSh    <= '0;
      resSh  <= '0;
      borrow <= 1'b0;
      hReg   <= 1'b0;
      aMsb   <= 1'b0;
      bMsb   <= 1'b0;
`ifdef SUB16_ZCHAIN_EN
      zcLat  <= 1'b0;
`endif
      done_o <= 1'b0;
      d_o    <= '0;
      c_o    <= 1'b0;
      z_o    <= 1'b0;
      n_o    <= 1'b0;
      v_o    <= 1'b0;
      s_o    <= 1'b0;
      h_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            aSh    <= a_i;
            bSh    <= b_i;
            aMsb   <= a_i[WIDTH-1];
            bMsb   <= b_i[WIDTH-1];
            borrow <= bi_i;
`ifdef SUB16_ZCHAIN_EN
            zcLat  <= zc_i;
`endif
            secCnt <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
          aSh    <= aSh >> 4;
          bSh    <= bSh >> 4;
          resSh  <= resFinal;
          borrow <= borrowNext;
          secCnt <= secCnt + 1'b1;
          // Half-borrow is the borrow out of bit 3, i.e. out of section 0.
          if (secCnt == '0) begin
            hReg <= borrowNext;
          end
          if (lastSec) begin
            // Publish result and flags together; they hold until the next completion.
            d_o    <= resFinal;
            c_o    <= borrowNext;
            z_o    <= zFinal;
            n_o    <= nFinal;
            v_o    <= vFinal;
            s_o    <= nFinal ^ vFinal;
            h_o    <= hReg;
            done_o <= 1'b1;
            state  <= DONE;
          end
        end

        DONE: begin
          // start_i is deliberately not sampled here; next start is taken from IDLE.
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub16_nibble_seq.sv
module tb_sub16_nibble_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startI = 1'b0;
  logic [15:0] aI = 16'h0000;
  logic [15:0] bI = 16'h0000;
  logic        biI = 1'b0;
  logic        zcI = 1'b0;
  logic        busyO, doneO;
  logic [15:0] dO;
  logic        cO, zO, nO, vO, sO, hO;
  logic [5:0]  fO;

  assign fO = {cO, zO, nO, vO, sO, hO};

`ifdef SUB16_ZCHAIN_EN
  localparam bit ZCH = 1'b1;
`else
  localparam bit ZCH = 1'b0;
`endif

  sub16_nibble_seq #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(startI),
    .a_i    (aI),
    .b_i    (bI),
    .bi_i   (biI),
    .zc_i   (zcI),
    .busy_o (busyO),
    .done_o (doneO),
    .d_o    (dO),
    .c_o    (cO),
    .z_o    (zO),
    .n_o    (nO),
    .v_o    (vO),
    .s_o    (sO),
    .h_o    (hO)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [5:0]  f;   // {C,Z,N,V,S,H}
  } exp_t;

  exp_t sbq[$];
  int   nVec = 0;
  int   nErr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected Z for a zero result, given the chained Z input.
  function automatic logic zx(input logic z, input logic zc);
    return z & (zc | ~ZCH);
  endfunction

  // Caller is at a negedge; advance negedges until the DUT is idle.
  task automatic waitIdle();
    int t = 0;
    while (busyO && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busyO) chk("idle_timeout", {31'd0, busyO}, 32'd0);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic bi,
                       input logic zc, input logic [15:0] expD, input logic [5:0] expF);
    waitIdle();
    aI = a; bI = b; biI = bi; zcI = zc; startI = 1'b1;
    sbq.push_back('{d: expD, f: expF});
    @(negedge clk);
    startI = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each done pulse; latency measured in busy cycles.
  int busyCnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busyO) busyCnt++; else busyCnt = 0;
      if (doneO) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", {31'd0, doneO}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("d_o", {16'd0, dO}, {16'd0, e.d});
          chk("flags_CZNVSH", {26'd0, fO}, {26'd0, e.f});
          chk("done_latency", busyCnt, 32'd5);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_d_o", {16'd0, dO}, 32'd0);
    chk("reset_flags", {26'd0, fO}, 32'd0);
    chk("reset_busy", {31'd0, busyO}, 32'd0);
    chk("reset_done", {31'd0, doneO}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    //     a        b        bi    zc    d         {C,Z,N,V,S,H}
    issue(16'h1234, 16'h0234, 1'b0, 1'b1, 16'h1000, 6'b000000);
    issue(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 6'b101011);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 6'b000111);
    issue(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 6'b101100);
    issue(16'h0005, 16'h0004, 1'b1, 1'b0, 16'h0000, {1'b0, zx(1'b1, 1'b0), 4'b0000});
    issue(16'h0005, 16'h0004, 1'b1, 1'b1, 16'h0000, {1'b0, zx(1'b1, 1'b1), 4'b0000});
    issue(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 6'b101011);
    issue(16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 6'b010000);

    // Starts held high with other operands through RUN and DONE must be ignored.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00FE, 6'b000000);
    aI = 16'h1111; bI = 16'h2222; biI = 1'b1; zcI = 1'b0; startI = 1'b1;
    // The next issue lands in the first IDLE cycle after DONE.
    issue(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 6'b000001);

    // Abort in the 2nd RUN cycle: no done, outputs cleared immediately.
    waitIdle();
    aI = 16'hAAAA; bI = 16'h5555; biI = 1'b0; zcI = 1'b1; startI = 1'b1;
    @(negedge clk);
    startI = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busyO}, 32'd0);
    chk("abort_done", {31'd0, doneO}, 32'd0);
    chk("abort_d_o", {16'd0, dO}, 32'd0);
    chk("abort_flags", {26'd0, fO}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 6'b000001);

    waitIdle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
